// File: rtl/modexp_pkg.sv
// Shared types and constants for the Montgomery modular exponentiator.
package modexp_pkg;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_EXP_WIDTH = 16;
  // Montgomery radix R = 2^R_EXP; the multiplier runs one iteration per radix bit.
  localparam int R_EXP             = 16;

  typedef enum logic [2:0] {
    IDLE,
    SQR,
    SQR_WAIT,
    MUL,
    MUL_WAIT,
    CONV,
    CONV_WAIT,
    FIN
  } state_t;

endpackage

// File: rtl/mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-R_EXP mod N, left in [0, 2N).
// Done pulses R_EXP+1 cycles after start is sampled; start is ignored while running.
module mont_mul
  import modexp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CW = (R_EXP > 1) ? $clog2(R_EXP) : 1;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH+1:0] s;
  logic [WIDTH+1:0] acc_add;
  logic [WIDTH+1:0] acc_red;
  logic [WIDTH+1:0] s_next;
  logic [CW-1:0]    cnt;
  logic             running;

  // Two guard bits: with s < 2N and b < N the partial sum stays below 4N.
  always_comb begin
    acc_add = s + (a_q[0] ? {2'b00, b_q} : '0);
    acc_red = acc_add + (acc_add[0] ? {2'b00, n} : '0);
    s_next  = acc_red >> 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s       <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (start && !running) begin
        a_q     <= a;
        b_q     <= b;
        s       <= '0;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        s   <= s_next;
        a_q <= a_q >> 1;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(R_EXP - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
          result  <= s_next[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/mont_modexp.sv
// Left-to-right square-and-multiply exponentiator over one shared Montgomery multiplier.
// Define MODEXP_FROM_MONT_EN to convert the result out of Montgomery form before done.
module mont_modexp
  import modexp_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int EXP_WIDTH = DEFAULT_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     n,
  input  logic [WIDTH-1:0]     base_mont,
  input  logic [WIDTH-1:0]     one_mont,
  input  logic [EXP_WIDTH-1:0] exp,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
`ifdef MODEXP_FROM_MONT_EN
  localparam state_t AFTER_LAST = CONV;
`else
  localparam state_t AFTER_LAST = FIN;
`endif

  state_t               state;
  logic [WIDTH-1:0]     n_q;
  logic [WIDTH-1:0]     base_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [WIDTH-1:0]     acc;
  logic [IW-1:0]        idx;
  logic                 mul_start;
  logic                 mul_done;
  logic [WIDTH-1:0]     mul_b;
  logic [WIDTH-1:0]     mul_res;
  logic [WIDTH-1:0]     reduced;
  state_t               next_bit;

  // The multiplier latches b on the first wait cycle, so select by the wait state.
  assign mul_b    = (state == MUL_WAIT)  ? base_q :
                    (state == CONV_WAIT) ? WIDTH'(1) : acc;
  assign reduced  = (mul_res >= n_q) ? mul_res - n_q : mul_res;
  assign next_bit = (idx == '0) ? AFTER_LAST : SQR;

  mont_mul #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (acc),
    .b      (mul_b),
    .n      (n_q),
    .result (mul_res),
    .done   (mul_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      n_q       <= '0;
      base_q    <= '0;
      exp_q     <= '0;
      acc       <= '0;
      idx       <= '0;
      mul_start <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_q    <= n;
            base_q <= base_mont;
            exp_q  <= exp;
            acc    <= one_mont;
            idx    <= IW'(EXP_WIDTH - 1);
            busy   <= 1'b1;
            state  <= SQR;
          end
        end
        SQR: begin
          mul_start <= 1'b1;
          state     <= SQR_WAIT;
        end
        SQR_WAIT: begin
          if (mul_done) begin
            acc <= reduced;
            if (exp_q[idx]) begin
              state <= MUL;
            end else begin
              state <= next_bit;
              if (idx != '0) idx <= idx - IW'(1);
            end
          end
        end
        MUL: begin
          mul_start <= 1'b1;
          state     <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (mul_done) begin
            acc   <= reduced;
            state <= next_bit;
            if (idx != '0) idx <= idx - IW'(1);
          end
        end
`ifdef MODEXP_FROM_MONT_EN
        CONV: begin
          mul_start <= 1'b1;
          state     <= CONV_WAIT;
        end
        CONV_WAIT: begin
          if (mul_done) begin
            acc   <= reduced;
            state <= FIN;
          end
        end
`endif
        FIN: begin
          result <= acc;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_modexp.sv
// Directed bench for mont_modexp; expectations follow the MODEXP_FROM_MONT_EN setting.
module tb_mont_modexp;
  import modexp_pkg::*;

  localparam int W       = 16;
  localparam int EW      = 16;
  localparam int MUL_LAT = R_EXP + 1;
`ifdef MODEXP_FROM_MONT_EN
  localparam int CONV_OPS = 1;
`else
  localparam int CONV_OPS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  n;
  logic [W-1:0]  base_mont;
  logic [W-1:0]  one_mont;
  logic [EW-1:0] exp;
  logic [W-1:0]  result;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mont_modexp #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n         (n),
    .base_mont (base_mont),
    .one_mont  (one_mont),
    .exp       (exp),
    .result    (result),
    .busy      (busy),
    .done      (done)
  );

  function automatic longint powmod(longint m, longint e, longint md);
    longint r = 1;
    longint b = m % md;
    while (e > 0) begin
      if (e[0]) r = (r * b) % md;
      b = (b * b) % md;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic longint to_mont(longint x, longint md);
    return (x << R_EXP) % md;
  endfunction

  // The DUT returns normal form only when conversion is built in.
  function automatic longint in_form(longint plain, longint md);
`ifdef MODEXP_FROM_MONT_EN
    return plain % md;
`else
    return to_mont(plain, md);
`endif
  endfunction

  function automatic int busy_expect(longint e);
    logic [EW-1:0] ev;
    ev = EW'(e);
    return (EW + $countones(ev) + CONV_OPS) * (MUL_LAT + 2) + 1;
  endfunction

  task automatic check(input string tag, input longint obs, input longint expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic run(input longint nn, input longint mm, input longint ee, input int restart_at,
                     output longint res, output int busy_cyc, output int dones);
    n         = W'(nn);
    base_mont = W'(to_mont(mm, nn));
    one_mont  = W'(to_mont(1, nn));
    exp       = EW'(ee);
    start     = 1'b1;
    busy_cyc  = 0;
    dones     = 0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (busy) busy_cyc++;
      if (done) begin
        dones++;
        break;
      end
      if (k == restart_at) begin
        n         = 16'd32749;
        base_mont = W'(to_mont(12345, 32749));
        one_mont  = W'(to_mont(1, 32749));
        exp       = 16'hFFFF;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    res   = longint'(result);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
  endtask

  initial begin
    longint res;
    int     bc;
    int     dn;

    rst = 1'b1; start = 1'b0; n = '0; base_mont = '0; one_mont = '0; exp = '0;
    #1;
    check("reset_busy",   longint'(busy),   0);
    check("reset_done",   longint'(done),   0);
    check("reset_result", longint'(result), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 2^5 mod 13 = 32 mod 13 = 6
    run(13, 2, 5, -1, res, bc, dn);
    check("n13_m2_e5_result", res, in_form(6, 13));
    check("n13_m2_e5_dones",  dn,  1);
    check("n13_m2_e5_busy",   bc,  busy_expect(5));

    // E=0 gives 1 (normal form) or R mod 13 = 3 (Montgomery form)
    run(13, 7, 0, -1, res, bc, dn);
    check("n13_m7_e0_result", res, in_form(1, 13));

    // 5^1 mod 13 = 5
    run(13, 5, 1, -1, res, bc, dn);
    check("n13_m5_e1_result", res, in_form(5, 13));

    run(32749, 12345, 16'hFFFF, -1, res, bc, dn);
    check("big_result", res, in_form(powmod(12345, 16'hFFFF, 32749), 32749));
    check("big_busy",   bc,  (16 + 16 + CONV_OPS) * (MUL_LAT + 2) + 1);
    check("big_dones",  dn,  1);

    // 3^7 mod 13: 3^3 = 27 = 1, so 3^7 = 3; a second start arrives 10 cycles in
    run(13, 3, 7, 10, res, bc, dn);
    check("restart_result", res, in_form(3, 13));
    check("restart_dones",  dn,  1);

    n = 16'd13; base_mont = W'(to_mont(2, 13)); one_mont = W'(to_mont(1, 13)); exp = 16'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy",   longint'(busy),   0);
    check("midrst_done",   longint'(done),   0);
    check("midrst_result", longint'(result), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("midrst_no_done", dn, 0);

    run(13, 2, 5, -1, res, bc, dn);
    check("after_rst_result", res, in_form(6, 13));
    check("after_rst_dones",  dn,  1);

    run(13, 0, 3, -1, res, bc, dn);
    check("base0_e3_result", res, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
